// File: rtl/lsu_writeback.sv
// Load/store sequencer between the execute stage and a synchronous data memory.
// One request is in flight at a time. A store occupies 2 cycles and a load
// occupies MEM_LAT+3 cycles. Load data comes back as a one-cycle write-back
// pulse to the register file.
module lsu_writeback #(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter int A       = 8,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_store,
    input  logic [A-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    input  logic [D-1:0] req_rd,
    output logic         mem_en,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    output logic         wb_valid,
    output logic [D-1:0] wb_addr,
    output logic [W-1:0] wb_data,
    output logic         busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    // The wait counter starts one below the latency, so the cycle in which
    // cnt reaches 0 is the cycle in which read data is valid.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic         store_q;
    logic [D-1:0] rd_q;
    logic [A-1:0] addr_q;
    logic [W-1:0] wdata_q;

    // Sequencer state and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (store_q) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the request on acceptance. mem_addr and mem_wdata come straight
    // from these registers, so they stay stable through ACCESS and WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= 1'b0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == S_IDLE && req_valid) begin
            store_q <= req_store;
            rd_q    <= req_rd;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Write-back registers load only when read data is sampled. They keep
    // their last value outside the write-back pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_addr <= '0;
            wb_data <= '0;
        end else if (state == S_WAIT && cnt == 4'd0) begin
            wb_addr <= rd_q;
            wb_data <= mem_rdata;
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = (state == S_ACCESS) && store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = (state == S_WB);

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback. Three builds run side by side
// (MEM_LAT = 2, 1, 15) on shared request inputs and a shared bench memory that
// returns a distinct value every cycle. A transaction-level reference model
// derives each build's expected outputs from the accept cycle of each request
// and its latency.
module tb_lsu_writeback;

    localparam int LAT [3] = '{2, 1, 15};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_store = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [2:0] req_rd = 3'd0;
    logic [7:0] mem_rdata;

    logic [2:0]      rdy, en, we, wbv, bsy;
    logic [2:0][7:0] maddr, mwd, wbd_o;
    logic [2:0][2:0] wba_o;

    int cyc = 0;
    int force_cyc = -1;
    logic [7:0] force_val = 8'h00;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per build.
    bit         act   [3];
    int         t_acc [3];
    bit         p_st  [3];
    logic [7:0] p_addr[3], p_wdata[3], sh_addr[3], sh_wdata[3], wbd[3];
    logic [2:0] p_rd  [3], wba[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench memory: a distinct value every cycle, with one optional override.
    assign mem_rdata = (cyc == force_cyc) ? force_val : 8'(cyc * 37 + 11);

    function automatic logic [7:0] mem_val(int c);
        if (c == force_cyc) return force_val;
        return 8'(c * 37 + 11);
    endfunction

    lsu_writeback #(.W(8), .D(3), .A(8), .MEM_LAT(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_en(en[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mem_rdata), .wb_valid(wbv[0]), .wb_addr(wba_o[0]), .wb_data(wbd_o[0]),
        .busy(bsy[0]));

    lsu_writeback #(.W(8), .D(3), .A(8), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_en(en[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mem_rdata), .wb_valid(wbv[1]), .wb_addr(wba_o[1]), .wb_data(wbd_o[1]),
        .busy(bsy[1]));

    lsu_writeback #(.W(8), .D(3), .A(8), .MEM_LAT(15)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_en(en[2]), .mem_we(we[2]), .mem_addr(maddr[2]), .mem_wdata(mwd[2]),
        .mem_rdata(mem_rdata), .wb_valid(wbv[2]), .wb_addr(wba_o[2]), .wb_data(wbd_o[2]),
        .busy(bsy[2]));

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d cycle=%0d observed=%0h expected=%0h", tag, LAT[k], cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            act[k] = 0; sh_addr[k] = 8'h00; sh_wdata[k] = 8'h00;
            wbd[k] = 8'h00; wba[k] = 3'd0;
        end
    endtask

    // Advance the model to the current cycle: captured values appear the cycle
    // after acceptance, the write-back pulse lands at accept+LAT+2 carrying the
    // memory value of accept+LAT+1, and the block frees up after its occupancy.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (act[k]) begin
                int occ;
                occ = p_st[k] ? 2 : LAT[k] + 3;
                if (cyc == t_acc[k] + 1) begin
                    sh_addr[k] = p_addr[k]; sh_wdata[k] = p_wdata[k];
                end
                if (!p_st[k] && cyc == t_acc[k] + LAT[k] + 2) begin
                    wba[k] = p_rd[k]; wbd[k] = mem_val(t_acc[k] + LAT[k] + 1);
                end
                if (cyc >= t_acc[k] + occ) act[k] = 0;
            end
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 3; k++) begin
            bit e_en, e_wbv;
            e_en  = act[k] && (cyc == t_acc[k] + 1);
            e_wbv = act[k] && !p_st[k] && (cyc == t_acc[k] + LAT[k] + 2);
            chk({tag, ".req_ready"}, k, 32'(rdy[k]), 32'(!act[k]));
            chk({tag, ".busy"},      k, 32'(bsy[k]), 32'(act[k]));
            chk({tag, ".mem_en"},    k, 32'(en[k]),  32'(e_en));
            chk({tag, ".mem_we"},    k, 32'(we[k]),  32'(e_en && p_st[k]));
            chk({tag, ".mem_addr"},  k, 32'(maddr[k]), 32'(sh_addr[k]));
            chk({tag, ".mem_wdata"}, k, 32'(mwd[k]),   32'(sh_wdata[k]));
            chk({tag, ".wb_valid"},  k, 32'(wbv[k]),   32'(e_wbv));
            chk({tag, ".wb_addr"},   k, 32'(wba_o[k]), 32'(wba[k]));
            chk({tag, ".wb_data"},   k, 32'(wbd_o[k]), 32'(wbd[k]));
        end
    endtask

    // One clock cycle: sample mid-cycle, update the model, compare.
    task automatic cycle(string tag);
        @(negedge clk);
        model_step();
        check_all(tag);
    endtask

    // Present inputs for the current cycle; every idle build accepts a valid request.
    task automatic drive(bit v, bit st, logic [7:0] a, logic [7:0] wd, logic [2:0] rd);
        req_valid = v; req_store = st; req_addr = a; req_wdata = wd; req_rd = rd;
        if (v) begin
            for (int k = 0; k < 3; k++) begin
                if (!act[k]) begin
                    act[k] = 1; t_acc[k] = cyc; p_st[k] = st;
                    p_addr[k] = a; p_wdata[k] = wd; p_rd[k] = rd;
                end
            end
        end
    endtask

    task automatic idle(string tag, int n);
        repeat (n) begin
            cycle(tag);
            drive(0, 0, 8'h00, 8'h00, 3'd0);
        end
    endtask

    // Asynchronous reset raised mid-cycle, checked before the next clock edge,
    // held across one edge, then released mid-cycle.
    task automatic reset_pulse(string tag);
        drive(0, 0, 8'h00, 8'h00, 3'd0);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all({tag, "_imm"});
        cycle({tag, "_hold"});
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        cycle("reset");
        cycle("reset");
        reset = 1'b0;
        idle("idle", 2);

        // Store 0x1F <- 0xA5
        cycle("store");
        drive(1, 1, 8'h1F, 8'hA5, 3'd0);
        idle("store", 4);

        // Load 0x40 -> r3; the memory returns 0x5C three cycles after acceptance
        cycle("load");
        force_cyc = cyc + 3;
        force_val = 8'h5C;
        drive(1, 0, 8'h40, 8'h00, 3'd3);
        idle("load", 20);

        // Request held continuously: load, then store
        cycle("b2b");
        drive(1, 0, 8'h22, 8'h00, 3'd5);
        repeat (5) begin
            cycle("b2b");
            drive(1, 1, 8'h33, 8'h77, 3'd0);
        end
        idle("b2b", 20);

        // Reset while mem_en is high
        cycle("rst_acc");
        drive(1, 0, 8'h55, 8'h00, 3'd2);
        cycle("rst_acc");
        reset_pulse("rst_acc");
        idle("rst_acc", 20);

        // Reset while every build is waiting on memory, then a clean load
        cycle("rst_wait");
        drive(1, 0, 8'h66, 8'h00, 3'd4);
        cycle("rst_wait");
        cycle("rst_wait");
        reset_pulse("rst_wait");
        idle("rst_wait", 20);
        cycle("after_rst");
        drive(1, 0, 8'h99, 8'h00, 3'd6);
        idle("after_rst", 20);

        // Randomised traffic with occasional resets
        repeat (600) begin
            cycle("rand");
            if ($urandom_range(0, 99) < 2) begin
                reset_pulse("rand_rst");
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom), 3'($urandom));
            end
        end
        idle("drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
